mem_stage: RTL and testbench

- MIPS32 memory-access pipeline stage, directly upstream of data_ram.
- Decodes the load/store op arriving from EX/MEM and drives the RAM ce/we/addr/sel/wData. Aligns and extends the RAM's combinational read data.
- Holds the LL/SC link bit, detects address-alignment errors, and owns the MEM/WB pipeline register feeding write-back.

---
 rtl/mem_stage_pkg.sv | 65 ++++++
 rtl/mem_stage_align.sv | 60 ++++++
 rtl/mem_stage.sv | 125 ++++++++++++
 tb/tb_mem_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS32 memory stage: op codes, bus levels and the
// memory-op decode used by the alignment unit and the stage register.
package mem_stage_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 8;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [OP_W-1:0] OP_LB  = 8'hE0;
  localparam logic [OP_W-1:0] OP_LH  = 8'hE1;
  localparam logic [OP_W-1:0] OP_LW  = 8'hE3;
  localparam logic [OP_W-1:0] OP_LBU = 8'hE4;
  localparam logic [OP_W-1:0] OP_LHU = 8'hE5;
  localparam logic [OP_W-1:0] OP_SB  = 8'hE8;
  localparam logic [OP_W-1:0] OP_SH  = 8'hE9;
  localparam logic [OP_W-1:0] OP_SW  = 8'hEB;
  localparam logic [OP_W-1:0] OP_LL  = 8'hF0;
  localparam logic [OP_W-1:0] OP_SC  = 8'hF8;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_load;
    logic      is_store;
    logic      sign_ext;
    logic      is_ll;
    logic      is_sc;
    mem_size_e size;
  } mem_dec_t;

  function automatic mem_dec_t decode_op(input logic [OP_W-1:0] op);
    mem_dec_t d;
    d = '{is_mem: 1'b0, is_load: 1'b0, is_store: 1'b0, sign_ext: 1'b0,
          is_ll: 1'b0, is_sc: 1'b0, size: SZ_NONE};
    case (op)
      OP_LB:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.sign_ext = 1'b1; d.size = SZ_BYTE; end
      OP_LH:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.sign_ext = 1'b1; d.size = SZ_HALF; end
      OP_LW:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.size = SZ_WORD; end
      OP_LBU: begin d.is_mem = 1'b1; d.is_load = 1'b1; d.size = SZ_BYTE; end
      OP_LHU: begin d.is_mem = 1'b1; d.is_load = 1'b1; d.size = SZ_HALF; end
      OP_SB:  begin d.is_mem = 1'b1; d.is_store = 1'b1; d.size = SZ_BYTE; end
      OP_SH:  begin d.is_mem = 1'b1; d.is_store = 1'b1; d.size = SZ_HALF; end
      OP_SW:  begin d.is_mem = 1'b1; d.is_store = 1'b1; d.size = SZ_WORD; end
      OP_LL:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.is_ll = 1'b1; d.size = SZ_WORD; end
      OP_SC:  begin d.is_mem = 1'b1; d.is_store = 1'b1; d.is_sc = 1'b1; d.size = SZ_WORD; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: big-endian select, store replication,
// load extraction/extension and address-alignment error detection.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic [OP_W-1:0]   i_op,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_sdata,
  input  logic [DATA_W-1:0] i_rdata,
  output mem_dec_t          o_dec,
  output logic [3:0]        o_sel,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_ldata,
  output logic              o_adel,
  output logic              o_ades
);

  mem_dec_t          w_dec;
  logic              w_misalign;
  logic [DATA_W-1:0] w_bshift;
  logic [DATA_W-1:0] w_hshift;

  assign w_dec = decode_op(i_op);
  assign o_dec = w_dec;

  // Lane 3 holds the lowest address, so the shift is (3 - addr) lanes.
  assign w_bshift = i_rdata >> {~i_addr_lo, 3'b000};
  assign w_hshift = i_rdata >> {~i_addr_lo[1], 4'b0000};

  always_comb begin
    o_sel      = 4'b0000;
    o_wdata    = ZERO_WORD;
    o_ldata    = ZERO_WORD;
    w_misalign = 1'b0;
    case (w_dec.size)
      SZ_BYTE: begin
        o_sel   = 4'b1000 >> i_addr_lo;
        o_wdata = {4{i_sdata[7:0]}};
        o_ldata = {{24{w_dec.sign_ext & w_bshift[7]}}, w_bshift[7:0]};
      end
      SZ_HALF: begin
        o_sel      = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_wdata    = {2{i_sdata[15:0]}};
        o_ldata    = {{16{w_dec.sign_ext & w_hshift[15]}}, w_hshift[15:0]};
        w_misalign = i_addr_lo[0];
      end
      SZ_WORD: begin
        o_sel      = 4'b1111;
        o_wdata    = i_sdata;
        o_ldata    = i_rdata;
        w_misalign = |i_addr_lo;
      end
      default: ;
    endcase
  end

  assign o_adel = w_misalign & w_dec.is_load;
  assign o_ades = w_misalign & w_dec.is_store;

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory stage: drives data_ram, resolves LL/SC via the link bit and
// holds the MEM/WB register with the address-error flags.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [OP_W-1:0]   i_ex_aluop,
  input  logic [ADDR_W-1:0] i_ex_addr,
  input  logic [DATA_W-1:0] i_ex_sdata,
  input  logic [REG_W-1:0]  i_ex_wd,
  input  logic              i_ex_wreg,
  input  logic [DATA_W-1:0] i_ex_wdata,
  output logic              o_ram_ce,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [3:0]        o_ram_sel,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [REG_W-1:0]  o_fwd_wd,
  output logic              o_fwd_wreg,
  output logic [DATA_W-1:0] o_fwd_wdata,
  output logic [REG_W-1:0]  o_wb_wd,
  output logic              o_wb_wreg,
  output logic [DATA_W-1:0] o_wb_wdata,
  output logic              o_exc_adel,
  output logic              o_exc_ades,
  output logic [ADDR_W-1:0] o_bad_vaddr,
  output logic              o_llbit
);

  mem_dec_t          w_dec;
  logic [DATA_W-1:0] w_ldata;
  logic              w_adel;
  logic              w_ades;
  logic              w_err;

  logic [REG_W-1:0]  r_wb_wd;
  logic              r_wb_wreg;
  logic [DATA_W-1:0] r_wb_wdata;
  logic              r_exc_adel;
  logic              r_exc_ades;
  logic [ADDR_W-1:0] r_bad_vaddr;
  logic              r_llbit;

  mem_stage_align u_align (
    .i_op      (i_ex_aluop),
    .i_addr_lo (i_ex_addr[1:0]),
    .i_sdata   (i_ex_sdata),
    .i_rdata   (i_ram_rdata),
    .o_dec     (w_dec),
    .o_sel     (o_ram_sel),
    .o_wdata   (o_ram_wdata),
    .o_ldata   (w_ldata),
    .o_adel    (w_adel),
    .o_ades    (w_ades)
  );

  assign w_err      = w_adel | w_ades;
  assign o_ram_addr = i_ex_addr;
  assign o_ram_ce   = (w_dec.is_mem && !w_err) ? CHIP_ENABLE : CHIP_DISABLE;

  // A failing SC still enables the chip but never writes.
  always_comb begin
    o_ram_we = WRITE_DISABLE;
    if (w_dec.is_store && !w_err && !i_stall && (!w_dec.is_sc || r_llbit))
      o_ram_we = WRITE_ENABLE;
  end

  always_comb begin
    o_fwd_wd    = i_ex_wd;
    o_fwd_wreg  = i_ex_wreg;
    o_fwd_wdata = i_ex_wdata;
    if (w_err) begin
      o_fwd_wreg = 1'b0;
    end else if (w_dec.is_sc) begin
      o_fwd_wreg  = 1'b1;
      o_fwd_wdata = {{(DATA_W-1){1'b0}}, r_llbit};
    end else if (w_dec.is_load) begin
      o_fwd_wdata = w_ldata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_wd     <= '0;
      r_wb_wreg   <= 1'b0;
      r_wb_wdata  <= ZERO_WORD;
      r_exc_adel  <= 1'b0;
      r_exc_ades  <= 1'b0;
      r_bad_vaddr <= '0;
      r_llbit     <= 1'b0;
    end else if (i_flush) begin
      r_wb_wd     <= '0;
      r_wb_wreg   <= 1'b0;
      r_wb_wdata  <= ZERO_WORD;
      r_exc_adel  <= 1'b0;
      r_exc_ades  <= 1'b0;
      r_bad_vaddr <= '0;
      r_llbit     <= 1'b0;
    end else if (!i_stall) begin
      r_wb_wd     <= o_fwd_wd;
      r_wb_wreg   <= o_fwd_wreg;
      r_wb_wdata  <= o_fwd_wdata;
      r_exc_adel  <= w_adel;
      r_exc_ades  <= w_ades;
      r_bad_vaddr <= w_err ? i_ex_addr : '0;
      if (w_dec.is_ll && !w_err)
        r_llbit <= 1'b1;
      else if (w_dec.is_sc && !w_err)
        r_llbit <= 1'b0;
    end
  end

  assign o_wb_wd     = r_wb_wd;
  assign o_wb_wreg   = r_wb_wreg;
  assign o_wb_wdata  = r_wb_wdata;
  assign o_exc_adel  = r_exc_adel;
  assign o_exc_ades  = r_exc_ades;
  assign o_bad_vaddr = r_bad_vaddr;
  assign o_llbit     = r_llbit;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a small behavioural data RAM attached.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_addr;
  logic [31:0] ex_sdata;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [4:0]  fwd_wd;
  logic        fwd_wreg;
  logic [31:0] fwd_wdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] bad_vaddr;
  logic        llbit;

  int n_cmp = 0;
  int n_err = 0;
  int write_cnt = 0;
  logic [31:0] mem [0:63];

  mem_stage dut (
    .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush),
    .i_ex_aluop(ex_aluop), .i_ex_addr(ex_addr), .i_ex_sdata(ex_sdata),
    .i_ex_wd(ex_wd), .i_ex_wreg(ex_wreg), .i_ex_wdata(ex_wdata),
    .o_ram_ce(ram_ce), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_sel(ram_sel), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_fwd_wd(fwd_wd), .o_fwd_wreg(fwd_wreg), .o_fwd_wdata(fwd_wdata),
    .o_wb_wd(wb_wd), .o_wb_wreg(wb_wreg), .o_wb_wdata(wb_wdata),
    .o_exc_adel(exc_adel), .o_exc_ades(exc_ades), .o_bad_vaddr(bad_vaddr),
    .o_llbit(llbit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural data_ram: combinational read, byte-selected write at posedge
  assign ram_rdata = mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      if (ram_sel[3]) mem[ram_addr[7:2]][31:24] <= ram_wdata[31:24];
      if (ram_sel[2]) mem[ram_addr[7:2]][23:16] <= ram_wdata[23:16];
      if (ram_sel[1]) mem[ram_addr[7:2]][15:8]  <= ram_wdata[15:8];
      if (ram_sel[0]) mem[ram_addr[7:2]][7:0]   <= ram_wdata[7:0];
      write_cnt++;
    end
  end

  // driver tasks
  task automatic drive(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] wd,
                       input logic wreg);
    @(negedge clk);
    ex_aluop = op; ex_addr = addr; ex_sdata = sdata;
    ex_wd = wd; ex_wreg = wreg; ex_wdata = 32'h0000_0000;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; flush = 1'b0;
    ex_aluop = 8'h00; ex_addr = '0; ex_sdata = '0; ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (2) step();
    n_cmp++;
    if ({wb_wd, wb_wreg, wb_wdata, exc_adel, exc_ades, bad_vaddr, llbit} !== 72'h0) begin
      n_err++; $display("FAIL reset_state: wb_wdata=%h wb_wreg=%b llbit=%b required all zero", wb_wdata, wb_wreg, llbit);
    end
    @(negedge clk); rst = 1'b0; stall = 1'b0;
  endtask

  task automatic test_word_byte();
    drive(8'hEB, 32'h10, 32'h1122_3344, 5'd0, 1'b0);
    n_cmp++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_sel !== 4'b1111 || ram_wdata !== 32'h1122_3344) begin
      n_err++; $display("FAIL sw_drive: ce=%b we=%b sel=%b wdata=%h required 1 1 1111 11223344", ram_ce, ram_we, ram_sel, ram_wdata);
    end
    step();
    drive(8'hE0, 32'h13, 32'h0, 5'd2, 1'b1);
    step();
    n_cmp++;
    if (wb_wdata !== 32'h0000_0044 || wb_wd !== 5'd2 || wb_wreg !== 1'b1) begin
      n_err++; $display("FAIL lb_0x13: wb_wdata=%h wd=%0d wreg=%b required 00000044 2 1", wb_wdata, wb_wd, wb_wreg);
    end
    drive(8'hE4, 32'h13, 32'h0, 5'd2, 1'b1);
    step();
    n_cmp++;
    if (wb_wdata !== 32'h0000_0044) begin
      n_err++; $display("FAIL lbu_0x13: wb_wdata=%h required 00000044", wb_wdata);
    end
    drive(8'hE0, 32'h10, 32'h0, 5'd2, 1'b1);
    step();
    n_cmp++;
    if (wb_wdata !== 32'h0000_0011) begin
      n_err++; $display("FAIL lb_0x10: wb_wdata=%h required 00000011", wb_wdata);
    end
  endtask

  task automatic test_byte_sign();
    drive(8'hE8, 32'h21, 32'h0000_0080, 5'd0, 1'b0);
    n_cmp++;
    if (ram_sel !== 4'b0100 || ram_wdata !== 32'h8080_8080) begin
      n_err++; $display("FAIL sb_drive: sel=%b wdata=%h required 0100 80808080", ram_sel, ram_wdata);
    end
    step();
    n_cmp++;
    if (mem[8] !== 32'h0080_0000) begin
      n_err++; $display("FAIL sb_ram: word=%h required 00800000", mem[8]);
    end
    drive(8'hE0, 32'h21, 32'h0, 5'd6, 1'b1);
    step();
    n_cmp++;
    if (wb_wdata !== 32'hFFFF_FF80) begin
      n_err++; $display("FAIL lb_sign: wb_wdata=%h required ffffff80", wb_wdata);
    end
    drive(8'hE4, 32'h21, 32'h0, 5'd6, 1'b1);
    step();
    n_cmp++;
    if (wb_wdata !== 32'h0000_0080) begin
      n_err++; $display("FAIL lbu_zero: wb_wdata=%h required 00000080", wb_wdata);
    end
  endtask

  task automatic test_half();
    drive(8'hE9, 32'h32, 32'h0000_BEEF, 5'd0, 1'b0);
    n_cmp++;
    if (ram_sel !== 4'b0011 || ram_wdata !== 32'hBEEF_BEEF) begin
      n_err++; $display("FAIL sh_drive: sel=%b wdata=%h required 0011 beefbeef", ram_sel, ram_wdata);
    end
    step();
    drive(8'hE1, 32'h32, 32'h0, 5'd7, 1'b1);
    step();
    n_cmp++;
    if (wb_wdata !== 32'hFFFF_BEEF) begin
      n_err++; $display("FAIL lh_sign: wb_wdata=%h required ffffbeef", wb_wdata);
    end
    drive(8'hE5, 32'h32, 32'h0, 5'd7, 1'b1);
    step();
    n_cmp++;
    if (wb_wdata !== 32'h0000_BEEF) begin
      n_err++; $display("FAIL lhu_zero: wb_wdata=%h required 0000beef", wb_wdata);
    end
  endtask

  task automatic test_misalign();
    int wc;
    drive(8'hE3, 32'h05, 32'h0, 5'd8, 1'b1);
    n_cmp++;
    if (ram_ce !== 1'b0 || fwd_wreg !== 1'b0) begin
      n_err++; $display("FAIL lw_misalign_ce: ce=%b fwd_wreg=%b required 0 0", ram_ce, fwd_wreg);
    end
    step();
    n_cmp++;
    if (exc_adel !== 1'b1 || exc_ades !== 1'b0 || bad_vaddr !== 32'h05 || wb_wreg !== 1'b0) begin
      n_err++; $display("FAIL lw_adel: adel=%b ades=%b bad=%h wreg=%b required 1 0 00000005 0", exc_adel, exc_ades, bad_vaddr, wb_wreg);
    end
    wc = write_cnt;
    drive(8'hE9, 32'h07, 32'h0000_1234, 5'd0, 1'b0);
    n_cmp++;
    if (ram_ce !== 1'b0 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL sh_misalign_drive: ce=%b we=%b required 0 0", ram_ce, ram_we);
    end
    step();
    n_cmp++;
    if (exc_ades !== 1'b1 || exc_adel !== 1'b0 || bad_vaddr !== 32'h07 || write_cnt !== wc) begin
      n_err++; $display("FAIL sh_ades: ades=%b adel=%b bad=%h writes=%0d required 1 0 00000007 %0d", exc_ades, exc_adel, bad_vaddr, write_cnt, wc);
    end
  endtask

  task automatic test_ll_sc();
    drive(8'hF0, 32'h40, 32'h0, 5'd4, 1'b1);
    step();
    n_cmp++;
    if (llbit !== 1'b1 || wb_wdata !== 32'h0) begin
      n_err++; $display("FAIL ll_set: llbit=%b wb_wdata=%h required 1 00000000", llbit, wb_wdata);
    end
    drive(8'hF8, 32'h40, 32'h5, 5'd5, 1'b1);
    n_cmp++;
    if (ram_we !== 1'b1 || fwd_wdata !== 32'h1) begin
      n_err++; $display("FAIL sc_ok_drive: we=%b fwd_wdata=%h required 1 00000001", ram_we, fwd_wdata);
    end
    step();
    n_cmp++;
    if (mem[16] !== 32'h5 || wb_wdata !== 32'h1 || wb_wreg !== 1'b1 || llbit !== 1'b0) begin
      n_err++; $display("FAIL sc_ok: ram=%h wb_wdata=%h wreg=%b llbit=%b required 00000005 00000001 1 0", mem[16], wb_wdata, wb_wreg, llbit);
    end
    drive(8'hF8, 32'h40, 32'h7, 5'd5, 1'b1);
    n_cmp++;
    if (ram_we !== 1'b0) begin
      n_err++; $display("FAIL sc_fail_we: we=%b required 0", ram_we);
    end
    step();
    n_cmp++;
    if (mem[16] !== 32'h5 || wb_wdata !== 32'h0 || wb_wreg !== 1'b1) begin
      n_err++; $display("FAIL sc_fail: ram=%h wb_wdata=%h wreg=%b required 00000005 00000000 1", mem[16], wb_wdata, wb_wreg);
    end
    drive(8'hF0, 32'h40, 32'h0, 5'd4, 1'b1);
    step();
    drive(8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    flush = 1'b1;
    step();
    n_cmp++;
    if (llbit !== 1'b0 || wb_wreg !== 1'b0 || wb_wd !== 5'd0) begin
      n_err++; $display("FAIL flush_clear: llbit=%b wreg=%b wd=%0d required 0 0 0", llbit, wb_wreg, wb_wd);
    end
    @(negedge clk); flush = 1'b0;
    drive(8'hF8, 32'h40, 32'h9, 5'd5, 1'b1);
    step();
    n_cmp++;
    if (mem[16] !== 32'h5 || wb_wdata !== 32'h0) begin
      n_err++; $display("FAIL sc_after_flush: ram=%h wb_wdata=%h required 00000005 00000000", mem[16], wb_wdata);
    end
  endtask

  task automatic test_stall();
    int wc;
    drive(8'hE3, 32'h10, 32'h0, 5'd3, 1'b1);
    step();
    wc = write_cnt;
    drive(8'hEB, 32'h50, 32'hCAFE_F00D, 5'd0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ram_we !== 1'b0) begin
        n_err++; $display("FAIL stall_we[%0d]: we=%b required 0", i, ram_we);
      end
      step();
      n_cmp++;
      if (wb_wdata !== 32'h1122_3344 || wb_wreg !== 1'b1 || wb_wd !== 5'd3 || write_cnt !== wc) begin
        n_err++; $display("FAIL stall_hold[%0d]: wb_wdata=%h wreg=%b wd=%0d writes=%0d required 11223344 1 3 %0d", i, wb_wdata, wb_wreg, wb_wd, write_cnt, wc);
      end
    end
    @(negedge clk); stall = 1'b0;
    step();
    n_cmp++;
    if (write_cnt !== wc + 1 || mem[20] !== 32'hCAFE_F00D || wb_wreg !== 1'b0) begin
      n_err++; $display("FAIL stall_release: writes=%0d ram=%h wreg=%b required %0d cafef00d 0", write_cnt, mem[20], wb_wreg, wc + 1);
    end
  endtask

  task automatic test_back_to_back();
    drive(8'h21, 32'h3, 32'h0, 5'd9, 1'b1);
    ex_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (ram_ce !== 1'b0 || fwd_wdata !== 32'hDEAD_BEEF || fwd_wd !== 5'd9 || fwd_wreg !== 1'b1) begin
      n_err++; $display("FAIL nonmem_fwd: ce=%b fwd=%h wd=%0d wreg=%b required 0 deadbeef 9 1", ram_ce, fwd_wdata, fwd_wd, fwd_wreg);
    end
    step();
    drive(8'hE3, 32'h50, 32'h0, 5'd10, 1'b1);
    n_cmp++;
    if (wb_wdata !== 32'hDEAD_BEEF || wb_wd !== 5'd9) begin
      n_err++; $display("FAIL nonmem_wb: wb_wdata=%h wd=%0d required deadbeef 9", wb_wdata, wb_wd);
    end
    step();
    n_cmp++;
    if (wb_wdata !== 32'hCAFE_F00D || wb_wd !== 5'd10) begin
      n_err++; $display("FAIL lw_b2b: wb_wdata=%h wd=%0d required cafef00d 10", wb_wdata, wb_wd);
    end
  endtask

  task automatic test_async_reset();
    int wc;
    drive(8'hF0, 32'h10, 32'h0, 5'd11, 1'b1);
    step();
    wc = write_cnt;
    drive(8'hEB, 32'h10, 32'h5555_AAAA, 5'd0, 1'b0);
    #2;
    rst = 1'b1; stall = 1'b1;
    #1;
    n_cmp++;
    if (wb_wdata !== 32'h0 || wb_wreg !== 1'b0 || wb_wd !== 5'd0 || llbit !== 1'b0 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL async_reset: wb_wdata=%h wreg=%b wd=%0d llbit=%b we=%b required 0 0 0 0 0", wb_wdata, wb_wreg, wb_wd, llbit, ram_we);
    end
    step();
    n_cmp++;
    if (write_cnt !== wc || mem[4] !== 32'h1122_3344) begin
      n_err++; $display("FAIL reset_no_write: writes=%0d ram=%h required %0d 11223344", write_cnt, mem[4], wc);
    end
    @(negedge clk); rst = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_byte();
    test_byte_sign();
    test_half();
    test_misalign();
    test_ll_sc();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
